// File: rtl/data_memory_256x32_pkg.sv
// Shared widths and word/address types for the 256 x 32 data memory.
package dm_pkg;

    localparam int unsigned DM_ADDR_W = 8;
    localparam int unsigned DM_DATA_W = 32;
    localparam int unsigned DM_DEPTH  = 256;

    typedef logic [DM_ADDR_W-1:0] dm_addr_t;
    typedef logic [DM_DATA_W-1:0] dm_word_t;

endpackage : dm_pkg

// File: rtl/data_memory_256x32_if.sv
// Data memory access bus: load/store port plus committed-store debug readback.
interface data_memory_256x32_if;
    import dm_pkg::*;

    logic        wea;
    dm_addr_t    addr;
    dm_word_t    din;
    dm_word_t    dout;
    logic        MDM_MemWrite;
    logic [31:0] sw_addr;
    logic [31:0] sw_regaddr;
    dm_word_t    res1;

    modport master (
        output wea, addr, din, MDM_MemWrite, sw_addr, sw_regaddr,
        input  dout, res1
    );

    modport slave (
        input  wea, addr, din, MDM_MemWrite, sw_addr, sw_regaddr,
        output dout, res1
    );

endinterface : data_memory_256x32_if

// File: rtl/data_memory_256x32.sv
// 256 x 32 word RAM: synchronous write, combinational read, registered store readback (res1).
// Define DM_TRACE_EN for a simulation trace of accepted writes and store captures.
module data_memory_256x32
    import dm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst2,
    data_memory_256x32_if.slave  bus
);

    dm_word_t mem [DM_DEPTH];
    dm_addr_t sw_idx;

    assign sw_idx = dm_addr_t'(bus.sw_addr[DM_ADDR_W-1:0]);

    // Array and res1 share one async-cleared block; res1 samples pre-edge contents.
    always_ff @(posedge clk or negedge rst2) begin
        if (!rst2) begin
            for (int i = 0; i < int'(DM_DEPTH); i++) begin
                mem[i] <= '0;
            end
            bus.res1 <= '0;
        end else begin
            if (bus.wea) begin
                mem[bus.addr] <= bus.din;
            end
            if (bus.MDM_MemWrite) begin
                bus.res1 <= mem[sw_idx];
            end
        end
    end

    assign bus.dout = mem[bus.addr];

`ifdef DM_TRACE_EN
    always @(posedge clk) begin
        if (rst2 && bus.wea) begin
            $display("%0t dm: write addr=%0d din=%h old=%h", $time, bus.addr, bus.din, mem[bus.addr]);
        end
        if (rst2 && bus.MDM_MemWrite) begin
            $display("%0t dm: store reg=%0d sw_addr=%h res1<=%h", $time, bus.sw_regaddr, bus.sw_addr, mem[sw_idx]);
        end
    end
`endif

    // Upper store-address bits and the trace-only register number carry no logic.
    logic unused_bits;
    assign unused_bits = ^{bus.sw_addr[31:DM_ADDR_W], bus.sw_regaddr};

endmodule : data_memory_256x32

// File: tb/tb_data_memory_256x32.sv
// Scoreboard bench for data_memory_256x32: directed plan plus random traffic vs a word-array model.
module tb_data_memory_256x32;
    import dm_pkg::*;

    logic clk;
    logic rst2;

    data_memory_256x32_if bus ();

    data_memory_256x32 dut (
        .clk  (clk),
        .rst2 (rst2),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dout;
        logic [31:0] res1;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];

    int passed;
    int total;

    // Reference model: plain word array plus the last captured store word.
    logic [31:0] model_mem [256];
    logic [31:0] model_res1;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
        model_res1 = 32'd0;
    endtask

    // Monitor: every negedge with an outstanding expectation compares dout and res1.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            total++;
            if (bus.dout === e.dout) passed++;
            else $display("FAIL %s dout: got %h expected %h", n, bus.dout, e.dout);
            total++;
            if (bus.res1 === e.res1) passed++;
            else $display("FAIL %s res1: got %h expected %h", n, bus.res1, e.res1);
        end
    end

    // Entered at posedge+1: drive, record expectation, then apply the edge to the model.
    task automatic cycle(input string n, input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic m, input logic [31:0] sa);
        bus.wea          = w;
        bus.addr         = a;
        bus.din          = d;
        bus.MDM_MemWrite = m;
        bus.sw_addr      = sa;
        bus.sw_regaddr   = $urandom_range(31, 0);
        exp_q.push_back('{dout: model_mem[a], res1: model_res1});
        name_q.push_back(n);
        @(posedge clk);
        if (rst2) begin
            if (m) model_res1 = model_mem[sa % 256];
            if (w) model_mem[a] = d;
        end
        #1;
    endtask

    task automatic rd(input string n, input logic [7:0] a);
        cycle(n, 1'b0, a, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        model_clear();
        rst2             = 1'b0;
        bus.wea          = 1'b0;
        bus.addr         = '0;
        bus.din          = '0;
        bus.MDM_MemWrite = 1'b0;
        bus.sw_addr      = '0;
        bus.sw_regaddr   = '0;
        repeat (2) @(posedge clk);
        #1 rst2 = 1'b1;

        rd("rst_a0", 8'd0);
        rd("rst_a1", 8'd1);
        rd("rst_a255", 8'd255);

        cycle("wr5", 1'b1, 8'd5, 32'hDEADBEEF, 1'b0, 32'd0);
        rd("rd5", 8'd5);
        rd("rd4", 8'd4);

        cycle("wr7_10", 1'b1, 8'd7, 32'd10, 1'b0, 32'd0);
        cycle("rdw7_before", 1'b1, 8'd7, 32'd20, 1'b0, 32'd0);
        rd("rdw7_after", 8'd7);

        cycle("wr3_42", 1'b1, 8'd3, 32'd42, 1'b0, 32'd0);
        cycle("cap3", 1'b0, 8'd3, 32'd0, 1'b1, 32'd3);
        cycle("hold_wr3_99", 1'b1, 8'd3, 32'd99, 1'b0, 32'd3);
        rd("hold_rd3", 8'd3);

        cycle("wrap259", 1'b0, 8'd3, 32'd0, 1'b1, 32'd259);
        rd("wrap_res1", 8'd7);

        // Async pulse between edges: clears without any clock edge.
        bus.addr = 8'd3;
        bus.wea  = 1'b0;
        bus.MDM_MemWrite = 1'b0;
        #2 rst2 = 1'b0;
        model_clear();
        exp_q.push_back('{dout: 32'd0, res1: 32'd0});
        name_q.push_back("async_rst");
        @(negedge clk);
        #1 rst2 = 1'b1;
        @(posedge clk);
        #1;
        rd("post_rst_a7", 8'd7);
        rd("post_rst_a5", 8'd5);

        // Reset held across an edge discards the write on that edge.
        cycle("pre_wr9", 1'b1, 8'd9, 32'h1234_5678, 1'b0, 32'd0);
        rst2 = 1'b0;
        model_clear();
        cycle("rst_wr9", 1'b1, 8'd9, 32'hCAFE_F00D, 1'b1, 32'd9);
        rst2 = 1'b1;
        rd("discard9", 8'd9);

        // Random traffic concentrated on a few words so writes, reads and captures collide.
        for (int i = 0; i < 400; i++) begin
            logic [7:0]  a;
            logic [31:0] sa;
            a  = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'($urandom_range(15, 0));
            sa = {$urandom_range(255, 0), 8'($urandom_range(15, 0))};
            sa = {8'd0, sa[23:0]} | (32'($urandom_range(1, 0)) << 31);
            cycle("rand", 1'($urandom), a, $urandom, 1'($urandom), sa);
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_data_memory_256x32

// File: doc/data_memory_256x32.md
Name: data_memory_256x32

Overview:
- Word-addressed data RAM, 256 x 32 bit, used by the pipeline MEMORY stage for lw/sw and for host preload.
- Synchronous write, asynchronous (combinational) read, so a load sees its data in the same cycle it presents the address.
- Extra registered debug port res1 returns the word at the address of the most recent committed store.

Parameters:
- ADDR_W, 8, word-address width; depth = 2**ADDR_W.
- DATA_W, 32, word width.

Ports:
- clk  input  1  rising-edge clock.
- rst2  input  1  reset, asynchronous, active-low; asserted when 0.
- wea  input  1  write enable for din -> mem[addr].
- addr  input  ADDR_W  word address for read and write.
- din  input  DATA_W  write data.
- dout  output  DATA_W  combinational read: mem[addr].
- MDM_MemWrite  input  1  registered "store committed last cycle" flag from the MEMORY stage.
- sw_addr  input  32  word address of that store; only bits [ADDR_W-1:0] are used.
- sw_regaddr  input  32  source register number of that store; trace only, no functional effect.
- res1  output  DATA_W  registered debug readback.

Behaviour:
- Reset (rst2=0, async): all 256 words cleared to 0; res1 cleared to 0.
  - dout then reads 0 combinationally.
  - Reset dominates wea.
  - Reset mid-operation discards any write on that edge.
- Write: on posedge clk with rst2=1 and wea=1, mem[addr] <= din. wea=0 leaves memory unchanged.
- Read: dout = mem[addr] at all times. There is no read enable and no read latency.
- Same-address write and read in one cycle:
  - before the edge, dout shows the old word;
  - after the edge, dout shows din.
- res1: on posedge clk with rst2=1 and MDM_MemWrite=1, res1 <= mem[sw_addr[ADDR_W-1:0]].
  - The value sampled is the pre-edge content.
  - A simultaneous write to the same word is not visible in res1 until the next MDM_MemWrite capture.
  - With MDM_MemWrite=0, res1 holds.
- Address wrap: only the low ADDR_W bits of sw_addr are used, so sw_addr=256 selects word 0. addr is already ADDR_W wide.
- X on wea is treated as no write; the model must not corrupt the array.

Optional Feature:
- Macro DM_TRACE_EN.
- Defined: on every accepted write, $display the time, addr, din and old value. When MDM_MemWrite=1, also display sw_regaddr, sw_addr and the captured res1.
- Undefined: no simulation output. Synthesised logic is identical either way; sw_regaddr is then unused.

Decomposition:
- Shared package dm_pkg holds:
  - DM_ADDR_W = 8, DM_DATA_W = 32, DM_DEPTH = 256;
  - typedefs dm_addr_t and dm_word_t.
- A single flat module is natural; no sub-module is needed.
- The array plus the res1 register fit in one always block with async reset.

Test Plan:
- Reset: drive rst2=0 for 2 cycles, then release -> dout=0 at addr 0, 1 and 255; res1=0.
- Write/read: wea=1, addr=5, din=32'hDEADBEEF, one edge, then wea=0 -> dout=32'hDEADBEEF at addr 5; addr 4 still reads 0.
- Read-during-write: mem[7]=10; set addr=7, din=20, wea=1 -> dout=10 before the edge and 20 after it.
- res1 capture: mem[3]=42; MDM_MemWrite=1, sw_addr=3 -> res1=42 after the edge.
  - Then MDM_MemWrite=0 and mem[3] overwritten with 99 -> res1 stays 42.
- Wrap plus async reset: sw_addr=259 with MDM_MemWrite=1 -> res1=mem[3].
  - Then pulse rst2 low between clock edges -> memory and res1 clear immediately, with no clock edge needed.
